// File: rtl/ac_sweep_sequencer.sv
// AC sweep sequencer: steps the stimulus NCO through a list of frequency words,
// lets the filter settle, and reports the mean rectified ADC amplitude per point.
module ac_sweep_sequencer #(
    parameter int FW    = 24,
    parameter int AW    = 12,
    parameter int NLOG2 = 8,
    parameter int PW    = 10
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          start,
    input  logic          abort,
    input  logic [FW-1:0] f_start,
    input  logic [FW-1:0] f_step,
    input  logic [PW-1:0] n_points,
    input  logic [15:0]   settle_cycles,
    output logic          busy,
    output logic [FW-1:0] nco_word,
    output logic          nco_load,
    input  logic          adc_valid,
    input  logic [AW-1:0] adc_data,
    output logic          res_valid,
    input  logic          res_ready,
    output logic [PW-1:0] res_index,
    output logic [FW-1:0] res_freq,
    output logic [AW-1:0] res_mag,
    output logic          done
);
    localparam int ACCW = AW + NLOG2;

    typedef enum logic [2:0] {
        S_IDLE   = 3'd0,
        S_LOAD   = 3'd1,
        S_SETTLE = 3'd2,
        S_ACQ    = 3'd3,
        S_REPORT = 3'd4,
        S_DONE   = 3'd5
    } state_t;

    state_t           r_state;
    logic [FW-1:0]    r_f_step;
    logic [FW-1:0]    r_freq;
    logic [PW-1:0]    r_n_points;
    logic [PW-1:0]    r_idx;
    logic [15:0]      r_settle;
    logic [15:0]      r_cnt;
    logic [ACCW-1:0]  r_acc;
    logic [NLOG2-1:0] r_nsamp;

    logic             r_busy;
    logic [FW-1:0]    r_nco_word;
    logic             r_nco_load;
    logic             r_res_valid;
    logic [PW-1:0]    r_res_index;
    logic [FW-1:0]    r_res_freq;
    logic [AW-1:0]    r_res_mag;
    logic             r_done;

    logic [AW-1:0]    w_mag;
    logic [ACCW-1:0]  w_acc_sum;
    logic [AW-1:0]    w_mean;
    logic             w_last_sample;
    logic             w_last_point;
    logic [FW-1:0]    w_freq_next;

    // Magnitude kept AW-bit unsigned so the most negative code maps to 2^(AW-1) exactly.
    function automatic logic [AW-1:0] abs_sample(input logic [AW-1:0] s);
        abs_sample = s[AW-1] ? (~s + {{(AW-1){1'b0}}, 1'b1}) : s;
    endfunction

    assign w_mag         = abs_sample(adc_data);
    assign w_acc_sum     = r_acc + {{NLOG2{1'b0}}, w_mag};
    assign w_mean        = w_acc_sum[ACCW-1:NLOG2];
    assign w_last_sample = (r_nsamp == {NLOG2{1'b1}});
    assign w_last_point  = (r_idx == (r_n_points - PW'(1)));
    assign w_freq_next   = r_freq + r_f_step;

    // Sweep FSM with all outputs registered alongside the state transitions.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state     <= S_IDLE;
            r_f_step    <= '0;
            r_freq      <= '0;
            r_n_points  <= '0;
            r_idx       <= '0;
            r_settle    <= 16'd0;
            r_cnt       <= 16'd0;
            r_acc       <= '0;
            r_nsamp     <= '0;
            r_busy      <= 1'b0;
            r_nco_word  <= '0;
            r_nco_load  <= 1'b0;
            r_res_valid <= 1'b0;
            r_res_index <= '0;
            r_res_freq  <= '0;
            r_res_mag   <= '0;
            r_done      <= 1'b0;
        end else begin
            r_nco_load <= 1'b0;
            r_done     <= 1'b0;
            if ((r_state != S_IDLE) && abort) begin
                r_state     <= S_IDLE;
                r_busy      <= 1'b0;
                r_res_valid <= 1'b0;
            end else begin
                case (r_state)
                    S_IDLE: begin
                        if (start) begin
                            r_f_step   <= f_step;
                            r_n_points <= n_points;
                            r_settle   <= settle_cycles;
                            r_freq     <= f_start;
                            r_idx      <= '0;
                            r_busy     <= 1'b1;
                            if (n_points == '0) begin
                                r_state <= S_DONE;
                                r_done  <= 1'b1;
                            end else begin
                                r_state    <= S_LOAD;
                                r_nco_word <= f_start;
                                r_nco_load <= 1'b1;
                            end
                        end
                    end
                    S_LOAD: begin
                        r_cnt   <= r_settle;
                        r_state <= S_SETTLE;
                    end
                    S_SETTLE: begin
                        if (r_cnt == 16'd0) begin
                            r_state <= S_ACQ;
                            r_acc   <= '0;
                            r_nsamp <= '0;
                        end else begin
                            r_cnt <= r_cnt - 16'd1;
                        end
                    end
                    S_ACQ: begin
                        if (adc_valid) begin
                            r_acc   <= w_acc_sum;
                            r_nsamp <= r_nsamp + NLOG2'(1);
                            if (w_last_sample) begin
                                r_res_mag   <= w_mean;
                                r_res_index <= r_idx;
                                r_res_freq  <= r_freq;
                                r_res_valid <= 1'b1;
                                r_state     <= S_REPORT;
                            end
                        end
                    end
                    S_REPORT: begin
                        if (res_ready) begin
                            r_res_valid <= 1'b0;
                            if (w_last_point) begin
                                r_state <= S_DONE;
                                r_done  <= 1'b1;
                            end else begin
                                r_idx      <= r_idx + PW'(1);
                                r_freq     <= w_freq_next;
                                r_nco_word <= w_freq_next;
                                r_nco_load <= 1'b1;
                                r_state    <= S_LOAD;
                            end
                        end
                    end
                    S_DONE: begin
                        r_state <= S_IDLE;
                        r_busy  <= 1'b0;
                    end
                    default: begin
                        r_state     <= S_IDLE;
                        r_busy      <= 1'b0;
                        r_res_valid <= 1'b0;
                    end
                endcase
            end
        end
    end

    assign busy      = r_busy;
    assign nco_word  = r_nco_word;
    assign nco_load  = r_nco_load;
    assign res_valid = r_res_valid;
    assign res_index = r_res_index;
    assign res_freq  = r_res_freq;
    assign res_mag   = r_res_mag;
    assign done      = r_done;

endmodule

// File: doc/ac_sweep_sequencer.md
# ac_sweep_sequencer

Digital sequencer for the automated AC frequency sweep of the two-stage op-amp bandpass test bench. For each sweep point it programs the stimulus NCO frequency word, waits a settling interval for the filter, integrates a block of rectified ADC samples of the filter output, and presents one magnitude result per point over a valid/ready handshake. It sits between the bench control registers, the stimulus NCO and the output-sampling ADC.

## Interface
Parameters:
- FW, 24: NCO frequency-word width.
- AW, 12: ADC sample width (signed two's complement).
- NLOG2, 8: log2 of samples averaged per point (2^NLOG2 samples).
- PW, 10: point-count / index width.

Ports:
- clk  in  1  single clock; all logic rising-edge.
- rst  in  1  asynchronous, active-high reset.
- start  in  1  one-cycle request to begin a sweep; sampled only in IDLE.
- abort  in  1  terminate the sweep; honoured in any non-IDLE state.
- f_start  in  FW  first frequency word; latched on accepted start.
- f_step  in  FW  per-point increment; latched on accepted start.
- n_points  in  PW  number of points; latched on accepted start.
- settle_cycles  in  16  settling wait per point; latched on accepted start.
- busy  out  1  high in every state except IDLE.
- nco_word  out  FW  current frequency word; held stable between loads.
- nco_load  out  1  one-cycle strobe; nco_word is valid in that cycle.
- adc_valid  in  1  ADC sample strobe.
- adc_data  in  AW  signed filter-output sample.
- res_valid  out  1  result available.
- res_ready  in  1  consumer accepts result.
- res_index  out  PW  point number, 0-based.
- res_freq  out  FW  frequency word of this point.
- res_mag  out  AW  mean absolute sample value of this point.
- done  out  1  one-cycle pulse at normal sweep completion.

## Operation
- States: IDLE, LOAD, SETTLE, ACQ, REPORT, DONE.
- IDLE: on start, latch the configuration, set freq=f_start and idx=0. Next state is LOAD, or DONE if n_points==0.
- LOAD: nco_word<=freq and nco_load=1 for exactly this cycle. Load the settle counter with settle_cycles. Next state is SETTLE.
- SETTLE: decrement the counter each cycle. Leave for ACQ in the cycle the counter reads 0, so SETTLE lasts settle_cycles+1 cycles. adc_valid is ignored.
- ACQ: clear the accumulator on entry. On each adc_valid, add |adc_data| and increment the sample count.
  - |−2^(AW−1)| = 2^(AW−1) exactly; treat the magnitude as AW-bit unsigned.
  - The accumulator is AW+NLOG2 bits and cannot overflow.
  - After the 2^NLOG2-th sample, register res_mag = acc >> NLOG2 (truncating), res_index=idx, res_freq=freq, and go to REPORT.
- REPORT: res_valid=1, and result fields are held stable until res_ready.
  - On the res_valid&&res_ready cycle: if idx==n_points−1, go to DONE. Otherwise idx+=1, freq+=f_step modulo 2^FW (wrap, no saturation), and go to LOAD.
- DONE: done=1 for one cycle, then IDLE.
- adc_valid outside ACQ is discarded. Samples are never counted across points.
- abort, any non-IDLE state: next state is IDLE, res_valid drops, no done pulse, nco_word retains its last value. abort has priority over every other transition in the same cycle.
- start while busy is ignored. Configuration-input changes while busy have no effect.

## Timing
- Reset values: busy=0, nco_word=0, nco_load=0, res_valid=0, res_index=0, res_freq=0, res_mag=0, done=0. State is IDLE.
- All outputs are registered; none is combinational from inputs.
- start seen at edge k: LOAD is the state in cycle k+1, so nco_load=1 in cycle k+1, and busy=1 from cycle k+1.
- Per point, minimum length: 1 (LOAD) + settle_cycles+1 (SETTLE) + 2^NLOG2 (ACQ, with adc_valid every cycle) + 1 (REPORT, with res_ready held) cycles.
- res_valid rises the cycle after the last ACQ sample is accepted.
- Back-pressure: res_ready low stalls in REPORT indefinitely. The next nco_load follows one cycle after the handshake.
- done asserts in the cycle after the final handshake, and busy falls in the cycle after done.
- Reset asserted mid-sweep: all outputs go to reset values immediately (asynchronous). Sweep state is not retained.

## Test plan
- Basic sweep (NLOG2=2, f_start=0x000100, f_step=0x000100, n_points=3, settle_cycles=4, adc_data=+100 constant, res_ready=1) -> three nco_load pulses with words 0x000100/0x000200/0x000300, res_mag=100 each, res_index 0,1,2, then one done pulse.
- Rectification/extremes: AW=12, ACQ samples alternating −2048 and +2047 (NLOG2=1) -> res_mag=2047. Samples {−5,+5,−5,+5} with NLOG2=2 -> res_mag=5.
- Back-pressure and wrap: f_start=0xFFFF00, f_step=0x000200, n_points=2, res_ready low for 10 cycles after first res_valid -> res fields stable for 10 cycles; second nco_word=0x000100.
- Edge counts: n_points=0 -> done one cycle after start with no nco_load. settle_cycles=0 -> SETTLE lasts exactly 1 cycle.
- Abort: abort during ACQ of point 1 of 4 -> IDLE next cycle, busy=0, no done, res_valid never asserts for point 1. A new start then sweeps normally from index 0.
- Async reset during REPORT with res_valid=1 -> all outputs 0 without a clock edge. adc_valid pulses during SETTLE are proven not to affect res_mag.
